data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Data-side memory stage downstream of the processor core's MEM pipeline stage.
- Consumes MemAddr/MemRead/MemWrite/WriteL/WriteR/WriteData and returns MemData, registered one cycle later, for use in the core's WB stage.
- Contains a word-organised RAM with halfword write lanes, plus a small memory-mapped I/O window (free-running cycle counter, store counter, output port).

Parameters:
- DEPTH, 1024, number of 32-bit RAM words; power of two, 4..16384.
- IO_BASE, 8'hFF, value of MemAddr[15:8] that selects the I/O window instead of RAM.

Ports:
- Clock      input   1   system clock, all state updates on rising edge
- nReset     input   1   asynchronous active-low reset
- MemAddr    input   16  byte address from core MEM stage
- MemRead    input   1   read request, sampled on Clock rising edge
- MemWrite   input   1   write request, sampled on Clock rising edge
- WriteL     input   1   upper-halfword lane select (bits 31:16)
- WriteR     input   1   lower-halfword lane select (bits 15:0)
- WriteData  input   32  store data
- MemData    output  32  registered read data, to core WB stage
- IoOut      output  32  output-port register
- CycleCount output  32  free-running cycle counter value

Behaviour:
- Reset (nReset low, asynchronous):
  - MemData=0, IoOut=0, CycleCount=0, StoreCount=0.
  - RAM contents are not reset.
  - Reset mid-operation discards any in-flight read; MemData=0 on the first cycle after release.
- Decode:
  - io_sel = (MemAddr[15:8]==IO_BASE).
  - RAM word index = MemAddr[log2(DEPTH)+1:2]. Upper bits alias. MemAddr[1:0] is ignored.
- Write lanes, applied at edge when MemWrite=1:
  - WriteL=0,WriteR=0 or WriteL=1,WriteR=1: full 32-bit word.
  - WriteL=1,WriteR=0: bits 31:16 only.
  - WriteL=0,WriteR=1: bits 15:0 only.
  - Unwritten lanes keep their value.
- Read latency is exactly 1 cycle.
  - MemRead=1 at edge N → MemData holds the read value from edge N until the next read edge.
  - With MemRead=0, MemData holds its previous value.
- Read and write in the same cycle to the same location are read-before-write: MemData gets the old value. The write completes at the same edge.
- Write at edge N, read of the same word sampled at edge N+1: returns the new data. No bypass is needed beyond normal RAM semantics.
- I/O window (io_sel=1), MemAddr[7:0] selects the register:
  - 8'h00 CycleCount: read-only; writes ignored. Increments by 1 every cycle out of reset and wraps 32'hFFFFFFFF → 0. A read at edge N returns the value before that edge's increment.
  - 8'h04 IoOut: read/write, lane rules as for RAM.
  - 8'h08 StoreCount: read-only. Increments on every RAM write (MemWrite=1 and io_sel=0); wraps at 32 bits.
  - Any other offset: reads return 0; writes are ignored.
- I/O accesses never touch RAM. IoOut updates at the write edge and is visible immediately after.
- MemRead and MemWrite both low: no state change except the counters.

Test Plan:
- Reset: hold nReset=0 for 3 cycles → MemData=0, IoOut=0, CycleCount=0. Release, wait 5 cycles → CycleCount=5.
- Full-word write then read: write 32'hDEADBEEF to 16'h0010 (WriteL=WriteR=0). Next cycle MemRead at 16'h0010 → MemData=32'hDEADBEEF one cycle later, held while MemRead=0.
- Halfword lanes: word 16'h0020=32'h11223344. Write 32'hAAAA5555 with WriteL=1 only → read 32'hAAAA3344. Then write 32'h0000BEEF with WriteR=1 only → read 32'hAAAABEEF.
- Simultaneous read/write same address: word=32'h1, write 32'h2 and read in the same cycle → MemData=32'h1; read next cycle → 32'h2.
- I/O: write 32'hCAFEF00D to 16'hFF04 → IoOut=32'hCAFEF00D, RAM word 16'h3F04&mask unchanged. Write to 16'hFF00 → CycleCount unaffected. Read 16'hFF0C → 0.
- Counters: after 4 RAM writes and 2 I/O writes, read 16'hFF08 → 32'h4. Force CycleCount to 32'hFFFFFFFF via preload in sim → next cycle 0.

Source files
------------

// File: rtl/data_mem.sv
// Data-side memory stage: word RAM with halfword write lanes plus a small
// memory-mapped I/O window (cycle counter, store counter, output port).
module data_mem #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [7:0]  IO_BASE = 8'hFF
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] MemAddr,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        WriteL,
  input  logic        WriteR,
  input  logic [31:0] WriteData,
  output logic [31:0] MemData,
  output logic [31:0] IoOut,
  output logic [31:0] CycleCount
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [7:0] OFF_CYCLE = 8'h00;
  localparam logic [7:0] OFF_IOOUT = 8'h04;
  localparam logic [7:0] OFF_STORE = 8'h08;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   storeCount;
  logic [31:0]   rdData;
  logic [AW-1:0] ramIdx;
  logic [7:0]    ioOff;
  logic          ioSel;
  logic          ramWr;
  logic          ioOutWr;
  logic          wrUpper;
  logic          wrLower;
  logic          unusedAddr;

  // Address decode; high bits above the RAM index alias, byte offset is ignored.
  assign ioSel      = (MemAddr[15:8] == IO_BASE);
  assign ioOff      = MemAddr[7:0];
  assign ramIdx     = MemAddr[AW+1:2];
  assign unusedAddr = ^MemAddr;

  // Both-or-neither lane selects mean a full-word store.
  assign wrUpper = WriteL | ~WriteR;
  assign wrLower = WriteR | ~WriteL;

  assign ramWr   = MemWrite & ~ioSel;
  assign ioOutWr = MemWrite & ioSel & (ioOff == OFF_IOOUT);

  // Read mux; values are pre-edge, giving read-before-write on a same-cycle store.
  always_comb begin
    rdData = '0;
    if (ioSel) begin
      case (ioOff)
        OFF_CYCLE: rdData = CycleCount;
        OFF_IOOUT: rdData = IoOut;
        OFF_STORE: rdData = storeCount;
        default:   rdData = '0;
      endcase
    end else begin
      rdData = mem[ramIdx];
    end
  end

  // RAM array is deliberately not reset.
  always_ff @(posedge Clock) begin
    if (ramWr) begin
      if (wrUpper) mem[ramIdx][31:16] <= WriteData[31:16];
      if (wrLower) mem[ramIdx][15:0]  <= WriteData[15:0];
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      MemData    <= '0;
      IoOut      <= '0;
      CycleCount <= '0;
      storeCount <= '0;
    end else begin
      CycleCount <= CycleCount + 32'd1;
      if (MemRead) MemData <= rdData;
      if (ramWr) storeCount <= storeCount + 32'd1;
      if (ioOutWr) begin
        if (wrUpper) IoOut[31:16] <= WriteData[31:16];
        if (wrLower) IoOut[15:0]  <= WriteData[15:0];
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: vector table for RAM/I-O traffic plus
// hand-written reset, counter and wrap sequences.
module tb_data_mem;

  logic        Clock;
  logic        nReset;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic        MemWrite;
  logic        WriteL;
  logic        WriteR;
  logic [31:0] WriteData;
  logic [31:0] MemData;
  logic [31:0] IoOut;
  logic [31:0] CycleCount;

  int checks = 0;
  int errors = 0;
  logic [31:0] cycModel;

  data_mem dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .MemAddr    (MemAddr),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .WriteL     (WriteL),
    .WriteR     (WriteR),
    .WriteData  (WriteData),
    .MemData    (MemData),
    .IoOut      (IoOut),
    .CycleCount (CycleCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference cycle count: rising edges seen since reset release.
  always @(posedge Clock or negedge nReset) begin
    if (!nReset) cycModel <= 32'd0;
    else         cycModel <= cycModel + 32'd1;
  end

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic        wl;
    logic        wrr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one access at a falling edge, let the rising edge take it, return at next falling edge.
  task automatic access(input logic [15:0] addr, input logic rd, input logic wr,
                        input logic wl, input logic wrr, input logic [31:0] wdata);
    MemAddr   = addr;
    MemRead   = rd;
    MemWrite  = wr;
    WriteL    = wl;
    WriteR    = wrr;
    WriteData = wdata;
    @(posedge Clock);
    @(negedge Clock);
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
  endtask

  initial begin
    nReset = 1'b0; MemAddr = '0; MemRead = 1'b0; MemWrite = 1'b0;
    WriteL = 1'b0; WriteR = 1'b0; WriteData = '0;

    // Reset state
    repeat (3) @(negedge Clock);
    check("rst_memdata", MemData, 32'h0);
    check("rst_ioout", IoOut, 32'h0);
    check("rst_cycle", CycleCount, 32'h0);
    nReset = 1'b1;
    repeat (5) @(negedge Clock);
    check("cycle_after5", CycleCount, 32'd5);

    // Store counter: 4 RAM writes, 2 I/O writes
    access(16'h0100, 0, 1, 0, 0, 32'h0000_0001);
    access(16'h0104, 0, 1, 0, 0, 32'h0000_0002);
    access(16'h0108, 0, 1, 1, 0, 32'h0003_0000);
    access(16'h010C, 0, 1, 0, 1, 32'h0000_0004);
    access(16'hFF04, 0, 1, 0, 0, 32'h1234_5678);
    access(16'hFF0C, 0, 1, 0, 0, 32'hFFFF_FFFF);
    access(16'hFF08, 1, 0, 0, 0, 32'h0);
    check("storecount", MemData, 32'h4);
    check("ioout_first", IoOut, 32'h1234_5678);
    check("cycle_model", CycleCount, cycModel);

    vecs.push_back('{"wr_full",      16'h0010, 0, 1, 0, 0, 32'hDEAD_BEEF, 0, 32'h0});
    vecs.push_back('{"rd_full",      16'h0010, 1, 0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF});
    vecs.push_back('{"hold1",        16'h0020, 0, 0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF});
    vecs.push_back('{"hold2",        16'h0030, 0, 0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF});
    vecs.push_back('{"wr_both",      16'h0020, 0, 1, 1, 1, 32'h1122_3344, 0, 32'h0});
    vecs.push_back('{"wr_upper",     16'h0020, 0, 1, 1, 0, 32'hAAAA_5555, 0, 32'h0});
    vecs.push_back('{"rd_upper",     16'h0020, 1, 0, 0, 0, 32'h0,         1, 32'hAAAA_3344});
    vecs.push_back('{"wr_lower",     16'h0020, 0, 1, 0, 1, 32'h0000_BEEF, 0, 32'h0});
    vecs.push_back('{"rd_lower",     16'h0020, 1, 0, 0, 0, 32'h0,         1, 32'hAAAA_BEEF});
    vecs.push_back('{"wr_one",       16'h0030, 0, 1, 0, 0, 32'h0000_0001, 0, 32'h0});
    vecs.push_back('{"rw_same",      16'h0030, 1, 1, 0, 0, 32'h0000_0002, 1, 32'h0000_0001});
    vecs.push_back('{"rd_after_rw",  16'h0030, 1, 0, 0, 0, 32'h0,         1, 32'h0000_0002});
    vecs.push_back('{"rd_other",     16'h0010, 1, 0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF});
    vecs.push_back('{"rd_alias_hi",  16'h1010, 1, 0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF});
    vecs.push_back('{"rd_byteoff",   16'h0023, 1, 0, 0, 0, 32'h0,         1, 32'hAAAA_BEEF});
    vecs.push_back('{"wr_alias",     16'h2020, 0, 1, 0, 0, 32'h5566_7788, 0, 32'h0});
    vecs.push_back('{"rd_aliased",   16'h0020, 1, 0, 0, 0, 32'h0,         1, 32'h5566_7788});
    vecs.push_back('{"wr_ram3f04",   16'h3F04, 0, 1, 0, 0, 32'h0BAD_F00D, 0, 32'h0});
    vecs.push_back('{"wr_io",        16'hFF04, 0, 1, 0, 0, 32'hCAFE_F00D, 0, 32'h0});
    vecs.push_back('{"rd_io",        16'hFF04, 1, 0, 0, 0, 32'h0,         1, 32'hCAFE_F00D});
    vecs.push_back('{"rd_ram_intact",16'h3F04, 1, 0, 0, 0, 32'h0,         1, 32'h0BAD_F00D});
    vecs.push_back('{"wr_io_lower",  16'hFF04, 0, 1, 0, 1, 32'h0000_BEEF, 0, 32'h0});
    vecs.push_back('{"rd_io_lower",  16'hFF04, 1, 0, 0, 0, 32'h0,         1, 32'hCAFE_BEEF});
    vecs.push_back('{"rd_io_hole",   16'hFF0C, 1, 0, 0, 0, 32'h0,         1, 32'h0});

    foreach (vecs[i]) begin
      access(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wl, vecs[i].wrr, vecs[i].wdata);
      if (vecs[i].chk) check(vecs[i].name, MemData, vecs[i].exp);
    end
    check("ioout_port", IoOut, 32'hCAFE_BEEF);

    // Writes to the cycle counter are ignored; reads return the pre-edge value
    access(16'hFF00, 0, 1, 0, 0, 32'h0000_0000);
    check("cycle_wr_ignored", CycleCount, cycModel);
    access(16'hFF00, 1, 0, 0, 0, 32'h0);
    check("cycle_read_pre", MemData, cycModel - 32'd1);

    // Wraparound from an injected all-ones count
    force dut.CycleCount = 32'hFFFF_FFFF;
    #1;
    release dut.CycleCount;
    #1;
    check("cycle_preload", CycleCount, 32'hFFFF_FFFF);
    @(posedge Clock);
    #1;
    check("cycle_wrap", CycleCount, 32'h0);
    @(negedge Clock);

    // Reset in the middle of a read
    access(16'h0010, 1, 0, 0, 0, 32'h0);
    check("rd_before_rst", MemData, 32'hDEAD_BEEF);
    MemAddr = 16'h0010;
    MemRead = 1'b1;
    #1;
    nReset = 1'b0;
    #1;
    check("async_rst_memdata", MemData, 32'h0);
    check("async_rst_ioout", IoOut, 32'h0);
    @(negedge Clock);
    MemRead = 1'b0;
    nReset = 1'b1;
    @(posedge Clock);
    #1;
    check("rst_release_memdata", MemData, 32'h0);
    check("rst_release_cycle", CycleCount, 32'd1);
    @(negedge Clock);
    access(16'hFF08, 1, 0, 0, 0, 32'h0);
    check("rst_storecount", MemData, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
